// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the PWM bank: address map, minimum period and
// breathe-direction encodings.
package pwm_bank_pkg;

  localparam int unsigned MIN_PERIOD = 2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // The period register sits just past the last duty register.
  function automatic int unsigned period_addr(input int unsigned nch);
    return nch;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty, breathe ramp and registered compare.
// Ports: clk, rst_n; cnt/wrap/period_act from the shared counter;
// wr/wr_data write duty_sh; en gates the output; breathe selects the ramp;
// pwm_out is the registered channel output.
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int unsigned CNT_W    = 27,
  parameter int unsigned DEF_DUTY = 50_000_000,
  parameter int unsigned STEP     = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wrap,
  input  logic [CNT_W-1:0] period_act,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             en,
  input  logic             breathe,
  output logic             pwm_out
);

  localparam int unsigned      XW       = CNT_W + 1;
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DEF_DUTY);
  localparam logic [XW-1:0]    STEP_X   = XW'(STEP);

  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] duty_act;
  logic             dir;

  logic [XW-1:0]    duty_x;
  logic [XW-1:0]    up_sum;
  logic [CNT_W-1:0] ramp_duty;
  logic             ramp_dir;

  // Next breathe duty/direction; one extra bit keeps the sum from wrapping.
  always_comb begin
    duty_x    = {1'b0, duty_act};
    up_sum    = duty_x + STEP_X;
    ramp_duty = duty_act;
    ramp_dir  = dir;
    if (dir == DIR_UP) begin
      if (up_sum >= {1'b0, period_act}) begin
        ramp_duty = period_act;
        ramp_dir  = DIR_DOWN;
      end else begin
        ramp_duty = up_sum[CNT_W-1:0];
      end
    end else begin
      if (duty_x <= STEP_X) begin
        ramp_duty = '0;
        ramp_dir  = DIR_UP;
      end else begin
        ramp_duty = CNT_W'(duty_x - STEP_X);
      end
    end
  end

  // Shadow write, commit/ramp at wrap, compare register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= DUTY_RST;
      duty_act <= DUTY_RST;
      dir      <= DIR_UP;
      pwm_out  <= 1'b0;
    end else begin
      if (wr) begin
        duty_sh <= wr_data;
      end
      if (wrap) begin
        if (breathe) begin
          duty_act <= ramp_duty;
          dir      <= ramp_dir;
        end else begin
          duty_act <= duty_sh;
        end
      end
      pwm_out <= en & (cnt < duty_act);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with a shared period counter.
// Ports: clk, rst_n; en/breathe per-channel controls; wr_en/wr_addr/wr_data
// register write port (addresses 0..NCH-1 duty, NCH period); pwm_out
// registered outputs; period_start pulses aligned with pwm_out at cnt==0.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int unsigned NCH        = 16,
  parameter int unsigned CNT_W      = 27,
  parameter int unsigned DEF_PERIOD = 100_000_000,
  parameter int unsigned DEF_DUTY   = 50_000_000,
  parameter int unsigned STEP       = 1_000_000,
  localparam int unsigned AW        = $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   breathe,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic [NCH-1:0]   pwm_out,
  output logic             period_start
);

  localparam logic [AW-1:0]    PERIOD_A   = AW'(period_addr(NCH));
  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] period_sh;
  logic             wrap;
  logic             period_wr;

  assign wrap      = (cnt == period_act - CNT_W'(1));
  assign period_wr = wr_en && (wr_addr == PERIOD_A) && (wr_data >= MIN_P);

  // Shared counter and period shadow/commit; period only changes at wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_act   <= PERIOD_RST;
      period_sh    <= PERIOD_RST;
      period_start <= 1'b0;
    end else begin
      if (wrap) begin
        cnt        <= '0;
        period_act <= period_sh;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (period_wr) begin
        period_sh <= wr_data;
      end
      period_start <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W    (CNT_W),
      .DEF_DUTY (DEF_DUTY),
      .STEP     (STEP)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt        (cnt),
      .wrap       (wrap),
      .period_act (period_act),
      .wr         (wr_en && (wr_addr == AW'(i))),
      .wr_data    (wr_data),
      .en         (en[i]),
      .breathe    (breathe[i]),
      .pwm_out    (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank (NCH=4, CNT_W=8, period 10, duty 5, step 2).
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  logic [3:0] breathe;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pwm_out;
  logic       period_start;

  always #5 clk = ~clk;

  pwm_bank #(
    .NCH(4), .CNT_W(8), .DEF_PERIOD(10), .DEF_DUTY(5), .STEP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .breathe(breathe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] sb_q[$];

  // Reference state
  int m_cnt, m_pact, m_psh;
  int m_dact[4];
  int m_dsh[4];
  int m_dir[4];

  int hi[4];
  int ps_seen;

  task automatic model_reset();
    m_cnt = 0; m_pact = 10; m_psh = 10;
    for (int i = 0; i < 4; i++) begin
      m_dact[i] = 5; m_dsh[i] = 5; m_dir[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    ps_seen = 0;
  endtask

  // One clock: push expected output, advance model, pop and compare.
  task automatic tick();
    logic [4:0] e;
    logic [4:0] got;
    int n_dact[4];
    int n_dsh[4];
    int n_dir[4];
    bit wrap;
    for (int i = 0; i < 4; i++) e[i] = en[i] && (m_cnt < m_dact[i]);
    e[4] = (m_cnt == 0);
    sb_q.push_back(e);
    wrap = (m_cnt == m_pact - 1);
    for (int i = 0; i < 4; i++) begin
      n_dact[i] = m_dact[i]; n_dsh[i] = m_dsh[i]; n_dir[i] = m_dir[i];
      if (wr_en && int'(wr_addr) == i) n_dsh[i] = int'(wr_data);
      if (wrap) begin
        if (!breathe[i]) n_dact[i] = m_dsh[i];
        else if (m_dir[i] == 0) begin
          if (m_dact[i] + 2 >= m_pact) begin n_dact[i] = m_pact; n_dir[i] = 1; end
          else n_dact[i] = m_dact[i] + 2;
        end else begin
          if (m_dact[i] <= 2) begin n_dact[i] = 0; n_dir[i] = 0; end
          else n_dact[i] = m_dact[i] - 2;
        end
      end
    end
    @(posedge clk);
    #1;
    if (wrap) begin m_cnt = 0; m_pact = m_psh; end
    else m_cnt = m_cnt + 1;
    if (wr_en && wr_addr == 3'd4 && wr_data >= 8'd2) m_psh = int'(wr_data);
    for (int i = 0; i < 4; i++) begin
      m_dact[i] = n_dact[i]; m_dsh[i] = n_dsh[i]; m_dir[i] = n_dir[i];
    end
    got = sb_q.pop_front();
    n_cmp++;
    assert ({period_start, pwm_out} === got) else begin
      n_bad++;
      $error("FAIL cycle_out: observed ps=%b pwm=%b expected ps=%b pwm=%b",
             period_start, pwm_out, got[4], got[3:0]);
    end
    for (int i = 0; i < 4; i++) if (pwm_out[i]) hi[i]++;
    if (period_start) ps_seen++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic align();
    while (m_cnt != 0) tick();
  endtask

  task automatic wr(input int addr, input int data);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = 8'(data);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bexp[9];
    bexp = '{7, 9, 10, 8, 6, 4, 2, 0, 2};
    rst_n = 1'b0; en = 4'hF; breathe = 4'h0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_ps", int'(period_start), 0);
    rst_n = 1'b1;

    // Defaults: 5 high / 5 low, one period_start per period
    clr(); run(10);
    chk("def_ch0_hi", hi[0], 5);
    chk("def_ch3_hi", hi[3], 5);
    chk("def_ps", ps_seen, 1);

    // Deferred duty write mid-period and in the wrap cycle
    clr(); run(4); wr(1, 3); run(5);
    chk("defer_cur", hi[1], 5);
    clr(); run(10);
    chk("defer_next", hi[1], 3);
    clr(); run(9); wr(1, 8);
    chk("wrapwr_cur", hi[1], 3);
    clr(); run(10);
    chk("wrapwr_next", hi[1], 3);
    clr(); run(10);
    chk("wrapwr_later", hi[1], 8);

    // Extremes: duty 0, duty > period, disabled channel
    wr(0, 0); wr(1, 12); en = 4'hB;
    align();
    clr(); run(20);
    chk("ext_ch0_low", hi[0], 0);
    chk("ext_ch1_high", hi[1], 20);
    chk("ext_ch2_off", hi[2], 0);
    chk("ext_ch3_norm", hi[3], 10);

    // Period change at cnt=7, then an ignored period=1 and out-of-range write
    run(7); wr(4, 4); run(2);
    clr(); run(8);
    chk("per4_ps", ps_seen, 2);
    chk("per4_ch3", hi[3], 8);
    wr(4, 1); wr(7, 3); run(2);
    clr(); run(8);
    chk("per1_ign_ps", ps_seen, 2);
    chk("badaddr_ch3", hi[3], 8);
    wr(4, 10); align();

    // Breathe on ch3
    breathe = 4'h8;
    clr(); run(10);
    chk("br_first", hi[3], 5);
    for (int k = 0; k < 9; k++) begin
      clr(); run(10);
      chk($sformatf("br_duty%0d", k), hi[3], bexp[k]);
    end

    // Async reset mid-period
    align(); run(6);
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_ps", int'(period_start), 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arst_hold", int'(pwm_out), 0);
    rst_n = 1'b1;
    clr(); run(10);
    chk("post_ch0", hi[0], 5);
    chk("post_ch1", hi[1], 5);
    chk("post_ch3", hi[3], 5);
    chk("post_ps", ps_seen, 1);
    clr(); run(10);
    chk("post_br_up", hi[3], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
